float_bundle_rx: RTL and testbench
==================================

// Module: float_bundle_rx
// PURPOSE
//  Byte-stream receiver for the float-constant bundle {sign, exponent, significand, foo[]}.
//  Accepts the bundle serialised as bytes over a valid/ready link.
//  Reassembles the frame and presents it as a registered parallel bundle with a valid/ready output.
//  Sits at the far end of a link from the block that drives the bundle as constants.
// PARAMETERS
//  EXP_W  8   exponent width
//  SIG_W  23  significand width
//  FOO_W  16  width of each foo element
//  FOO_N  3   number of foo elements
//  (derived) TOTAL_W = 1+EXP_W+SIG_W+FOO_N*FOO_W (80); NBYTES = ceil(TOTAL_W/8) (10)
// PORTS
//  clock           in   1              single clock, all logic on rising edge
//  reset           in   1              synchronous, active-low
//  in_valid        in   1              input byte valid
//  in_ready        out  1              receiver can accept a byte
//  in_data         in   8              input byte
//  in_last         in   1              marks final byte of a frame
//  io_valid        out  1              bundle outputs hold a complete frame
//  io_ready        in   1              consumer accepts the frame
//  io_sign         out  1              sign field
//  io_exponent     out  EXP_W          exponent field
//  io_significand  out  SIG_W          significand field
//  io_foo          out  FOO_N*FOO_W    foo[i] = io_foo[i*FOO_W +: FOO_W]
//  frame_err       out  1              1-cycle pulse on a framing error
//  csum_err        out  1              1-cycle pulse on a checksum mismatch (0 when feature is off)
// BEHAVIOUR
//  Frame vector F = {sign, exponent, significand, foo[N-1], ..., foo[0]}.
//  Byte k = F[8k+7:8k]; sent little-endian, byte 0 first.
//  Pad bits of the last byte are ignored.
//  A byte transfers when in_valid && in_ready.
//  A frame transfers when io_valid && io_ready.
//  States:
//   COLLECT: in_ready=1. Shift each byte into a shadow register; byte counter cnt counts 0..NBYTES-1.
//   HOLD:    in_ready=0, io_valid=1. Go to COLLECT with cnt=0 on io_ready.
//   DROP:    in_ready=1. Discard bytes; go to COLLECT with cnt=0 on an accepted byte with in_last.
//  Good frame: accepted byte with cnt==NBYTES-1 and in_last=1.
//   - Output fields load from the shadow register.
//   - io_valid rises the next cycle, so latency is 1 cycle after the last byte.
//   - Go to HOLD.
//  Output fields change only on a good-frame load; they are stable while io_valid=1.
//  Early last: in_last=1 with cnt<NBYTES-1.
//   - Pulse frame_err, discard the partial frame, cnt=0, stay in COLLECT.
//  Missing last: cnt==NBYTES-1 and in_last=0.
//   - Pulse frame_err, discard, go to DROP.
//  No skid buffer: in_ready is 0 throughout HOLD, including the io_ready cycle.
//  Peak rate is one frame per NBYTES+1 cycles.
//  Reset (reset==0 at an edge, including mid-frame or mid-HOLD):
//   - state=COLLECT, cnt=0, shadow register=0
//   - io_valid=0, all io_* fields=0, frame_err=0, csum_err=0
//   - in_ready=1 from the first cycle after reset is released
// CONFIGURATION
//  FLOAT_RX_CSUM_EN defined:
//   - Each frame carries one extra trailing byte (index NBYTES): the XOR of data bytes 0..NBYTES-1.
//   - in_last goes with the checksum byte; framing rules apply with length NBYTES+1.
//   - On mismatch: pulse csum_err, discard the frame (no load, no io_valid), return to COLLECT.
//  FLOAT_RX_CSUM_EN undefined:
//   - No checksum byte; frame length is NBYTES.
//   - csum_err is tied to 0.
// TESTING
//  1. Good frame, defaults:
//     bytes 16 00 21 00 2c 00 80 00 00 85, in_last on the last byte
//     -> 1 cycle later io_valid=1, sign=1, exp=0x0a, sig=0x80, foo={0x2c,0x21,0x16}.
//  2. Backpressure: hold io_ready=0 for 5 cycles
//     -> io_valid stays 1, fields stable, in_ready=0.
//     io_ready=1 -> in_ready=1 the next cycle.
//  3. Early last: in_last on byte 4
//     -> frame_err pulses once, no io_valid.
//     A following good frame is delivered correctly.
//  4. Missing last: 12 bytes with no in_last, then a byte with in_last
//     -> one frame_err pulse, all bytes dropped, next frame is good.
//  5. Reset asserted after byte 6 of a frame
//     -> all outputs 0; a fresh 10-byte frame is received intact.
//  6. FLOAT_RX_CSUM_EN:
//     frame from test 1 plus 0x1e -> delivered;
//     frame from test 1 plus 0x1f -> csum_err pulses once, io_valid stays 0.

Source files
------------

// File: rtl/float_bundle_rx.sv
// Byte-stream receiver that reassembles the {sign, exponent, significand, foo[]} bundle.
// Define FLOAT_RX_CSUM_EN to require a trailing XOR checksum byte on every frame.
module float_bundle_rx #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned SIG_W = 23,
    parameter int unsigned FOO_W = 16,
    parameter int unsigned FOO_N = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   io_valid,
    input  logic                   io_ready,
    output logic                   io_sign,
    output logic [EXP_W-1:0]       io_exponent,
    output logic [SIG_W-1:0]       io_significand,
    output logic [FOO_N*FOO_W-1:0] io_foo,
    output logic                   frame_err,
    output logic                   csum_err
);

    localparam int unsigned FOO_TW  = FOO_N * FOO_W;
    localparam int unsigned TOTAL_W = 1 + EXP_W + SIG_W + FOO_TW;
    localparam int unsigned NBYTES  = (TOTAL_W + 7) / 8;
`ifdef FLOAT_RX_CSUM_EN
    localparam int unsigned FLEN    = NBYTES + 1;
`else
    localparam int unsigned FLEN    = NBYTES;
`endif
    // Bytes parked in the shadow register before the frame-closing byte arrives.
    localparam int unsigned SH_W    = (FLEN - 1) * 8;
    localparam int unsigned CNT_W   = $clog2(FLEN);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SH_W-1:0]      shadow_q;
    logic [SH_W-1:0]      shadow_d;
    logic                 io_valid_q;
    logic                 io_sign_q;
    logic [EXP_W-1:0]     io_exponent_q;
    logic [SIG_W-1:0]     io_significand_q;
    logic [FOO_TW-1:0]    io_foo_q;
    logic                 frame_err_q;
    logic                 accept;
    logic                 last_slot;
    logic [TOTAL_W-1:0]   frame_w;

    assign accept    = in_valid && in_ready;
    assign last_slot = (cnt_q == CNT_W'(FLEN - 1));

    always_comb begin
        shadow_d = shadow_q;
        if (!last_slot)
            shadow_d[{cnt_q, 3'b000} +: 8] = in_data;
    end

`ifdef FLOAT_RX_CSUM_EN
    logic [7:0] csum_q;
    logic       csum_err_q;

    assign frame_w  = shadow_q[TOTAL_W-1:0];
    assign csum_err = csum_err_q;
`else
    logic [NBYTES*8-1:0] frame_all;

    // Final data byte is taken straight from the input so the load needs no extra cycle.
    assign frame_all = {in_data, shadow_q};
    assign frame_w   = frame_all[TOTAL_W-1:0];
    assign csum_err  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= S_COLLECT;
            cnt_q            <= '0;
            shadow_q         <= '0;
            io_valid_q       <= 1'b0;
            io_sign_q        <= 1'b0;
            io_exponent_q    <= '0;
            io_significand_q <= '0;
            io_foo_q         <= '0;
            frame_err_q      <= 1'b0;
`ifdef FLOAT_RX_CSUM_EN
            csum_q           <= '0;
            csum_err_q       <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef FLOAT_RX_CSUM_EN
            csum_err_q  <= 1'b0;
`endif
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        if (last_slot) begin
                            cnt_q <= '0;
                            if (!in_last) begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_DROP;
`ifdef FLOAT_RX_CSUM_EN
                            end else if (in_data != csum_q) begin
                                csum_err_q <= 1'b1;
`endif
                            end else begin
                                io_sign_q        <= frame_w[TOTAL_W-1];
                                io_exponent_q    <= frame_w[TOTAL_W-2 -: EXP_W];
                                io_significand_q <= frame_w[FOO_TW +: SIG_W];
                                io_foo_q         <= frame_w[FOO_TW-1:0];
                                io_valid_q       <= 1'b1;
                                state_q          <= S_HOLD;
                            end
                        end else if (in_last) begin
                            frame_err_q <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q    <= cnt_q + 1'b1;
                            shadow_q <= shadow_d;
`ifdef FLOAT_RX_CSUM_EN
                            csum_q   <= (cnt_q == '0) ? in_data : (csum_q ^ in_data);
`endif
                        end
                    end
                end
                S_HOLD: begin
                    if (io_ready) begin
                        io_valid_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_COLLECT;
                    end
                end
                S_DROP: begin
                    if (accept && in_last) begin
                        cnt_q   <= '0;
                        state_q <= S_COLLECT;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

    assign in_ready       = (state_q != S_HOLD);
    assign io_valid       = io_valid_q;
    assign io_sign        = io_sign_q;
    assign io_exponent    = io_exponent_q;
    assign io_significand = io_significand_q;
    assign io_foo         = io_foo_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_float_bundle_rx.sv
// Scoreboard bench for float_bundle_rx: directed frames, framing errors, backpressure, reset.
// Follows FLOAT_RX_CSUM_EN to append checksum bytes and run the checksum cases.
module tb_float_bundle_rx;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        io_valid;
    logic        io_ready = 1'b1;
    logic        io_sign;
    logic [7:0]  io_exponent;
    logic [22:0] io_significand;
    logic [47:0] io_foo;
    logic        frame_err;
    logic        csum_err;

`ifdef FLOAT_RX_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] sg;
        logic [47:0] foo;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     fe_seen = 0;
    int     ce_seen = 0;
    int     frames_seen = 0;

    float_bundle_rx #(
        .EXP_W(8),
        .SIG_W(23),
        .FOO_W(16),
        .FOO_N(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .io_valid(io_valid),
        .io_ready(io_ready),
        .io_sign(io_sign),
        .io_exponent(io_exponent),
        .io_significand(io_significand),
        .io_foo(io_foo),
        .frame_err(frame_err),
        .csum_err(csum_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: counts error pulses and compares every transferred frame against the queue.
    always @(negedge clock) begin
        frame_t e;
        if (reset) begin
            if (frame_err === 1'b1) fe_seen++;
            if (csum_err === 1'b1) ce_seen++;
            if (io_valid === 1'b1 && io_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 128'd1, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sign", 128'(io_sign), 128'(e.s));
                    check("exponent", 128'(io_exponent), 128'(e.e));
                    check("significand", 128'(io_significand), 128'(e.sg));
                    check("foo", 128'(io_foo), 128'(e.foo));
                    frames_seen++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int unsigned w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 50) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 128'd0, 128'd1);
        end else begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [79:0] v, input frame_t expv, input bit push,
                              input bit csum_ovr, input logic [7:0] csum_val);
        logic [7:0] x = '0;
        if (push) exp_q.push_back(expv);
        for (int k = 0; k < 10; k++) begin
            x ^= v[8*k +: 8];
            send_byte(v[8*k +: 8], !CSUM && (k == 9));
        end
        if (CSUM) send_byte(csum_ovr ? csum_val : x, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] v1;
        frame_t f1, f2, f3, f4, f5;
        v1 = 80'h85_00_00_80_00_2c_00_21_00_16;
        f1 = {1'b1, 8'h0a, 23'h000080, 48'h002c_0021_0016};
        f2 = {1'b0, 8'h81, 23'h2aaaaa, 48'hbeef_1234_a5c3};
        f3 = {1'b1, 8'h00, 23'h000001, 48'hffff_0000_8001};
        f4 = {1'b1, 8'hff, 23'h7fffff, 48'hffff_ffff_ffff};
        f5 = {1'b0, 8'h7f, 23'h400000, 48'h0102_0304_0506};

        // Reset state
        idle(3);
        check("rst_io_valid", 128'(io_valid), 128'd0);
        check("rst_fields", 128'({io_sign, io_exponent, io_significand, io_foo}), 128'd0);
        check("rst_errs", 128'({frame_err, csum_err}), 128'd0);
        reset = 1'b1;
        idle(1);
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // Test 1: good frame, one-cycle latency
        send_frame(v1, f1, 1'b1, 1'b0, 8'h00);
        check("t1_latency_valid", 128'(io_valid), 128'd1);
        check("t1_hold_in_ready", 128'(in_ready), 128'd0);
        idle(1);
        check("t1_frames", 128'(frames_seen), 128'd1);
        check("t1_valid_drop", 128'(io_valid), 128'd0);

        // Test 2: backpressure
        io_ready = 1'b0;
        send_frame(80'(f2), f2, 1'b1, 1'b0, 8'h00);
        check("t2_valid", 128'(io_valid), 128'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("t2_hold_valid", 128'(io_valid), 128'd1);
            check("t2_hold_in_ready", 128'(in_ready), 128'd0);
            check("t2_hold_fields", 128'({io_sign, io_exponent, io_significand, io_foo}), 128'(f2));
        end
        io_ready = 1'b1;
        idle(1);
        check("t2_release_in_ready", 128'(in_ready), 128'd1);
        check("t2_release_valid", 128'(io_valid), 128'd0);
        check("t2_frames", 128'(frames_seen), 128'd2);

        // Test 3: early last on byte 4
        for (int k = 0; k < 5; k++) send_byte(8'(k + 8'h40), k == 4);
        idle(3);
        check("t3_frame_err", 128'(fe_seen), 128'd1);
        check("t3_no_valid", 128'(io_valid), 128'd0);
        send_frame(80'(f3), f3, 1'b1, 1'b0, 8'h00);
        idle(2);
        check("t3_frames", 128'(frames_seen), 128'd3);

        // Test 4: missing last, then drop until last
        for (int k = 0; k < 12; k++) send_byte(8'(k * 7 + 3), 1'b0);
        send_byte(8'h5a, 1'b1);
        idle(3);
        check("t4_frame_err", 128'(fe_seen), 128'd2);
        check("t4_no_valid", 128'(io_valid), 128'd0);
        send_frame(80'(f4), f4, 1'b1, 1'b0, 8'h00);
        idle(2);
        check("t4_frames", 128'(frames_seen), 128'd4);

        // Test 5: reset mid-frame
        begin
            logic [79:0] v5;
            v5 = 80'(f5);
            for (int k = 0; k < 7; k++) send_byte(v5[8*k +: 8], 1'b0);
        end
        reset = 1'b0;
        idle(1);
        check("t5_rst_valid", 128'(io_valid), 128'd0);
        check("t5_rst_fields", 128'({io_sign, io_exponent, io_significand, io_foo}), 128'd0);
        check("t5_rst_errs", 128'({frame_err, csum_err}), 128'd0);
        reset = 1'b1;
        idle(1);
        check("t5_in_ready", 128'(in_ready), 128'd1);
        send_frame(80'(f5), f5, 1'b1, 1'b0, 8'h00);
        idle(2);
        check("t5_frames", 128'(frames_seen), 128'd5);

`ifdef FLOAT_RX_CSUM_EN
        // Test 6: checksum good and bad
        send_frame(v1, f1, 1'b1, 1'b1, 8'h1e);
        idle(2);
        check("t6_good_frames", 128'(frames_seen), 128'd6);
        send_frame(v1, f1, 1'b0, 1'b1, 8'h1f);
        check("t6_bad_no_valid", 128'(io_valid), 128'd0);
        idle(3);
        check("t6_csum_err", 128'(ce_seen), 128'd1);
        check("t6_frames", 128'(frames_seen), 128'd6);
`else
        check("no_csum_err", 128'(ce_seen), 128'd0);
`endif

        check("final_frame_err", 128'(fe_seen), 128'd2);
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
